// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the DFF BIST checker.
// State encoding, LFSR taps and seed handling.
package dff_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  // x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // An all-zero LFSR never leaves zero, so map it to 1.
  function automatic logic [7:0] fix_seed(
    input logic [7:0] s
  );
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, left shifting.
// msb is the current bit, msb_nxt the bit after one shift.
module lfsr8
  import dff_bist_pkg::*;
#(
  parameter logic [7:0] INIT = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       shift,
  output logic       msb,
  output logic       msb_nxt
);

  logic [7:0] q;
  logic       fb;

  assign fb      = ^(q & LFSR_TAPS);
  assign msb     = q[7];
  assign msb_nxt = q[6];

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= fix_seed(INIT);
    end else if (load) begin
      q <= fix_seed(seed);
    end else if (shift) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/dff_bist_checker.sv
// Drives a PRBS into a DFF under test and checks that
// Q returns each bit one clock later.
module dff_bist_checker
  import dff_bist_pkg::*;
#(
  parameter int         RUN_LEN = 64,
  parameter logic [7:0] SEED    = DEFAULT_SEED,
  parameter int         ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             d_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_err
);

  localparam logic [7:0] SEED_OK = fix_seed(SEED);
  localparam logic [7:0] LAST_IX = 8'(RUN_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic       armed;
  logic       accept;
  logic       last;
  logic       mismatch;
  logic       expected;
  logic [7:0] idx;
  logic       lfsr_msb;
  logic       lfsr_msb_nxt;

  assign busy     = (state == S_PRIME) || (state == S_RUN);
  assign done     = (state == S_DONE);
  assign pass     = done && (err_count == '0);
  assign last     = (idx == LAST_IX);
  assign mismatch = (state == S_RUN) && (q_in != expected);

  lfsr8 #(
    .INIT(SEED_OK)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .seed   (SEED_OK),
    .shift  (busy),
    .msb    (lfsr_msb),
    .msb_nxt(lfsr_msb_nxt)
  );

  // Next state; start only counts when idle/done and armed.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (1'b1)
      (state == S_IDLE),
      (state == S_DONE): begin
        if (armed && start) begin
          state_nxt = S_PRIME;
          accept    = 1'b1;
        end
      end
      (state == S_PRIME): state_nxt = S_RUN;
      (state == S_RUN): begin
        if (last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // First edge after reset release only samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  // Stimulus, expected bit, index and error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out     <= 1'b0;
      expected  <= 1'b0;
      idx       <= 8'd0;
      err_count <= '0;
      first_err <= 8'd0;
    end else if (accept) begin
      d_out     <= SEED_OK[7];
      expected  <= 1'b0;
      idx       <= 8'd0;
      err_count <= '0;
      first_err <= 8'd0;
    end else if (state == S_PRIME) begin
      expected <= lfsr_msb;
      d_out    <= lfsr_msb_nxt;
      idx      <= 8'd1;
    end else if (state == S_RUN) begin
      expected <= lfsr_msb;
      if (mismatch) begin
        if (err_count != ERR_MAX)
          err_count <= err_count + 1'b1;
        if (first_err == 8'd0)
          first_err <= idx;
      end
      if (last) begin
        d_out <= 1'b0;
      end else begin
        d_out <= lfsr_msb_nxt;
        idx   <= idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dff_bist_checker.sv
// Bench for dff_bist_checker: loopback DFF model,
// cycle-by-cycle model check and directed scenarios.
module tb_dff_bist_checker;

  localparam int RUN_LEN = 64;
  localparam int ERR_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       q_in;
  logic       d_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] first_err;

  logic       d_sat;
  logic       busy_sat;
  logic       done_sat;
  logic       pass_sat;
  logic [3:0] err_sat;
  logic [7:0] first_sat;

  logic q_reg  = 1'b0;
  logic stuck0 = 1'b0;
  logic flip   = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  bit bseq[0:RUN_LEN];

  always #5 clk = ~clk;

  // Ideal DFF under test, with optional faults.
  always @(posedge clk) q_reg <= d_out;
  assign q_in = stuck0 ? 1'b0 : (q_reg ^ flip);

  dff_bist_checker #(
    .RUN_LEN(RUN_LEN),
    .SEED   (8'hA5),
    .ERR_W  (8)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d_out    (d_out),
    .q_in     (q_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .first_err(first_err)
  );

  // Q wired straight to D: every transition is a miscompare.
  dff_bist_checker #(
    .RUN_LEN(RUN_LEN),
    .SEED   (8'hA5),
    .ERR_W  (4)
  ) u_sat (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .d_out    (d_sat),
    .q_in     (d_sat),
    .busy     (busy_sat),
    .done     (done_sat),
    .pass     (pass_sat),
    .err_count(err_sat),
    .first_err(first_sat)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference bit sequence b0..b64 from the polynomial.
  task automatic gen_seq();
    logic [7:0] s;
    logic       fb;
    s = 8'hA5;
    for (int k = 0; k <= RUN_LEN; k++) begin
      bseq[k] = s[7];
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      s  = {s[6:0], fb};
    end
  endtask

  // Model: position in the test and accumulated results.
  bit m_act   = 1'b0;
  bit m_done  = 1'b0;
  bit m_armed = 1'b0;
  int m_pos   = 0;
  int m_err   = 0;
  int m_first = 0;

  always @(posedge clk) begin : model_check
    logic sq;
    logic ss;
    logic sr;
    int   exp_d;
    sq = q_in;
    ss = start;
    sr = rst;
    if (sr) begin
      m_act = 0; m_done = 0; m_armed = 0;
      m_pos = 0; m_err = 0; m_first = 0;
    end else begin
      if (m_act) begin
        if (m_pos >= 1 && sq != bseq[m_pos-1]) begin
          if (m_err < ERR_MAX) m_err++;
          if (m_first == 0) m_first = m_pos;
        end
        if (m_pos == RUN_LEN) begin
          m_act  = 0;
          m_done = 1;
        end else begin
          m_pos++;
        end
      end else if (m_armed && ss) begin
        m_act = 1; m_done = 0; m_pos = 0;
        m_err = 0; m_first = 0;
      end
      m_armed = 1;
    end
    #2;
    exp_d = m_act ? int'(bseq[m_pos]) : 0;
    chk("cyc_busy", busy, m_act);
    chk("cyc_done", done, m_done);
    chk("cyc_pass", pass, m_done && m_err == 0);
    chk("cyc_d_out", d_out, exp_d);
    chk("cyc_err_count", err_count, m_err);
    chk("cyc_first_err", first_err, m_first);
  end

  // One test: pulse start, optionally flip Q or re-pulse start.
  task automatic run(
    input  int flip_at,
    input  int restart_at,
    output int nb
  );
    nb = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy) nb++;
      if (done) break;
      start = (restart_at != 0 && nb == restart_at + 1);
      flip  = (flip_at != 0 && nb == flip_at + 1);
      @(negedge clk);
    end
    start = 1'b0;
    flip  = 1'b0;
    chk("run_done_in_budget", done, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    int nb;
    int ones;
    int first1;
    int trans;
    gen_seq();

    chk("model_b0", bseq[0], 1);
    chk("model_b1", bseq[1], 0);
    chk("model_b2", bseq[2], 1);
    chk("model_b5", bseq[5], 1);

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err, 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_d_out", d_out, 0);
    end

    // Ideal loopback.
    run(0, 0, nb);
    chk("loop_busy_cycles", nb, 65);
    chk("loop_pass", pass, 1);
    chk("loop_err", err_count, 0);
    chk("loop_first", first_err, 0);

    // Saturating counter alongside.
    trans = 0;
    for (int k = 1; k <= RUN_LEN; k++)
      if (bseq[k] != bseq[k-1]) trans++;
    chk("sat_done", done_sat, 1);
    chk("sat_err_model", err_sat,
        (trans < 15) ? trans : 15);
    chk("sat_err_lit", err_sat, 15);
    chk("sat_pass", pass_sat, 0);

    // Stuck-at-0.
    ones = 0;
    first1 = -1;
    for (int k = 0; k < RUN_LEN; k++) begin
      if (bseq[k]) begin
        ones++;
        if (first1 < 0) first1 = k;
      end
    end
    stuck0 = 1'b1;
    run(0, 0, nb);
    stuck0 = 1'b0;
    chk("sa0_err", err_count, ones);
    chk("sa0_first", first_err, first1 + 1);
    chk("sa0_first_lit", first_err, 1);
    chk("sa0_pass", pass, 0);

    // Single flip at compare index 10, then a clean rerun.
    run(10, 0, nb);
    chk("flip_err", err_count, 1);
    chk("flip_first", first_err, 10);
    chk("flip_pass", pass, 0);
    run(0, 0, nb);
    chk("rerun_pass", pass, 1);

    // start re-pulsed at RUN index 5 is ignored.
    run(0, 5, nb);
    chk("repulse_busy_cycles", nb, 65);
    chk("repulse_pass", pass, 1);

    // Reset mid-test at RUN index 20 with errors pending.
    stuck0 = 1'b1;
    nb = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy) nb++;
      if (nb == 21) break;
      @(negedge clk);
    end
    chk("mid_reached_ix20", nb, 21);
    chk("mid_err_nonzero", err_count != 0, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d_out", d_out, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_first", first_err, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    stuck0 = 1'b0;

    // start while reset releases is ignored.
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rel_start_ignored", busy, 0);
    repeat (2) @(negedge clk);
    chk("rel_still_idle", busy, 0);

    run(0, 0, nb);
    chk("final_busy_cycles", nb, 65);
    chk("final_pass", pass, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_bist_checker.md
# dff_bist_checker

On-chip stimulus generator and response checker for the single-bit D flip-flop tile. It is the driving and monitoring end of the DFF's D/Q interface: it drives a pseudo-random bit stream into D and checks that Q returns each bit exactly one clock later. It accumulates a saturating mismatch count and records the first failing index. It sits beside the DFF inside the tile top-level, and its result is exposed on dedicated outputs.

## Interface
Parameters:
- `RUN_LEN`, 64: number of compare cycles per test, legal range 1–255.
- `SEED`, 8'hA5: LFSR seed. A value of 0 is illegal, and the block substitutes 8'h01.
- `ERR_W`, 8: width of the mismatch counter.

Ports:
- `clk` in 1: rising-edge clock, shared with the DFF under test.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a test. Sampled on the rising edge.
- `d_out` out 1: bit driven to the D input of the DFF under test.
- `q_in` in 1: Q output of the DFF under test.
- `busy` out 1: high while a test is in progress (PRIME or RUN).
- `done` out 1: level, high in DONE until the next accepted `start`.
- `pass` out 1: equals `done && err_count == 0`.
- `err_count` out ERR_W: saturating count of mismatches.
- `first_err` out 8: compare index (1..RUN_LEN) of the first mismatch. Value is 0 when there is none.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- Reset:
  - state goes to IDLE and the LFSR loads SEED.
  - `d_out`, `busy`, `done`, `pass`, `err_count`, `first_err` all go to 0.
  - The compare index and the expected-bit register also clear.
- IDLE or DONE with `start` = 1:
  - next state is PRIME.
  - LFSR reloads SEED, and `err_count`, `first_err` and the index clear.
  - `done` drops.
- `start` in PRIME or RUN is ignored. It is neither queued nor treated as a restart.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifted left once per cycle in PRIME and RUN. Driven bit b_k = lfsr[7] after k shifts.
- PRIME (1 cycle): drive b0, latch `expected` = b0, no compare. Go to RUN with index = 1.
- RUN, cycle i = 1..RUN_LEN:
  - Compare `q_in` with `expected` (= b_{i-1}).
  - Drive b_i and latch `expected` = b_i.
  - After i = RUN_LEN, go to DONE.
- On mismatch:
  - `err_count` increments, saturating at 2^ERR_W−1.
  - If `first_err` is 0, it loads i.
- `d_out` = 0 in IDLE and DONE. The DFF is left holding the last driven bit for one cycle, which is not checked.
- DONE holds all results until the next accepted `start` or `rst`.

## Timing
- `start` is accepted at edge T0. Then:
  - PRIME during cycle T0→T1, so `busy` = 1 from T0+.
  - RUN spans edges T1..T_RUN_LEN; the compare at edge T_i uses the `q_in` value sampled at that edge.
  - `done`/`pass` are valid from edge T_{RUN_LEN+1}.
- `busy` is high for exactly 1+RUN_LEN cycles.
- `d_out` is registered, so it changes only after a clock edge. `q_in` is sampled without a synchronizer (same clock domain).
- `err_count` and `first_err` update registered on the compare edge.
- Simultaneous saturation and mismatch: the count holds at maximum, and `first_err` is unaffected if already set.
- `rst` mid-test: all outputs clear immediately (asynchronous), and no partial result survives.
- `start` in the same cycle `rst` deasserts: `start` is ignored, and the first edge after deassertion only samples.

## Structure
- Package `dff_bist_pkg` holds:
  - the state enum (IDLE, PRIME, RUN, DONE).
  - the LFSR tap constant 8'hB8.
  - the default seed constant.
  - the nonzero-seed fix-up function.
- Sub-module `lfsr8`: 8-bit Fibonacci LFSR with `load`/`seed`/`shift` inputs and `msb` output.
- The FSM, compare logic and counters stay in `dff_bist_checker`.

## Test plan
- Reset: hold `rst` for 3 cycles. All outputs read 0 and `d_out` stays 0 with `start` low for 10 cycles.
- Ideal loopback (bench model: `q_in` <= `d_out` on clk), single `start` pulse. Required: `busy` high for 65 cycles, then `done` = 1, `pass` = 1, `err_count` = 0, `first_err` = 0.
- Stuck-at-0 (`q_in` tied to 0). Required: `err_count` = number of ones in the bench-model sequence b0..b63, and `first_err` = 1 + the index of the first 1 in that sequence. `pass` = 0.
- Single injected flip at compare index 10 in the loopback. Required: `err_count` = 1, `first_err` = 10. A rerun via `start` with no flip must then give `pass` = 1.
- Saturation: ERR_W = 4 with `q_in` = `d_out` (no delay). Required: `err_count` = min(15, transitions in b0..b64), with 15 expected for SEED = 8'hA5.
- `rst` pulse at RUN index 20, and separately `start` re-pulsed at RUN index 5:
  - The reset case clears all outputs asynchronously, before the next edge.
  - The re-pulse case leaves the run unaffected, with `busy` still totalling 65 cycles.
